cache_mem_responder: RTL and testbench
======================================

Name: cache_mem_responder

Overview:
- Main-memory responder on the memory side of the direct-mapped data cache. It services the cache's outgoing requests: line refills on a read miss, and single-word write-through stores.
- Read requests return one cache line as a LINE_WORDS-beat burst after a programmable access latency.
- Write requests update one word in a single cycle.
- Read and write transaction counters are kept for miss-traffic statistics.

Parameters:
- LINE_WORDS, 4, words per cache line; power of two, >= 2.
- LATENCY, 8, cycles from read accept to first response beat; >= 1.
- MEM_AW, 14, word-address bits of the backing array (16384 words).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = word write, 0 = line read.
- req_addr  in  32  byte address; word index = req_addr[MEM_AW+1:2]; bits above are ignored (aliasing).
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read beat present.
- rsp_ready  in  1  cache accepts the beat.
- rsp_data  out  DATA_W  read beat data.
- rsp_last  out  1  final beat of the line.
- busy  out  1  state != IDLE.
- rd_count  out  32  completed line reads; wraps modulo 2^32.
- wr_count  out  32  accepted writes; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; rsp_valid=0, rsp_last=0, rsp_data=0, rd_count=0, wr_count=0.
  - Array contents are not reset and persist across reset.
  - Reset mid-WAIT or mid-BURST abandons the transaction. No residual beats; rd_count is not incremented.
- req_ready = (state==IDLE). Combinational from state only, never from req_valid.
- IDLE:
  - Accept on req_valid && req_ready.
  - Write accept: mem[idx] <= req_wdata at that edge; wr_count+1; remain IDLE. Back-to-back writes are allowed, one per cycle.
  - Read accept: base <= idx with low log2(LINE_WORDS) bits cleared (line-aligned, sequential order, no critical-word-first). beat <= 0; lat_cnt <= LATENCY-1; go to WAIT.
- WAIT:
  - If lat_cnt==0, go to BURST; otherwise lat_cnt-1.
  - First beat: rsp_valid rises exactly LATENCY cycles after the accept edge.
- BURST:
  - rsp_data is registered. It is loaded with mem[base+0] on the WAIT->BURST edge, and with mem[base+beat+1] on each handshake that is not the last beat.
  - rsp_last = (beat==LINE_WORDS-1), registered alongside rsp_data.
  - Handshake = rsp_valid && rsp_ready:
    - On a non-last beat: beat+1; rsp_valid stays high, giving one beat per cycle under continuous rsp_ready.
    - On the last beat: rsp_valid and rsp_last go to 0 next cycle; rd_count+1; go to IDLE. The next request can be accepted in the cycle after return to IDLE (one idle-bubble minimum between a line read and the next request).
  - Backpressure: while rsp_valid && !rsp_ready, rsp_data, rsp_last and beat hold stable.
- Requests are not accepted outside IDLE. req_* are don't-care while req_ready=0.
- A read always covers the whole aligned line, even if req_addr is mid-line. The base never crosses the array end because the line is aligned.
- Write data read back in a later line read returns the written value. A write and a read are never simultaneous (single request port).

Decomposition:
- Package cache_mem_pkg:
  - state enum {IDLE, WAIT, BURST};
  - default constants for LINE_WORDS, LATENCY, MEM_AW, DATA_W;
  - function clog2 for beat width.
- Sub-module cache_mem_array: single-port synchronous word RAM, 2^MEM_AW x DATA_W, with one write port and one registered read port. The FSM, latency counter, beat counter and statistics counters stay in the top module.

Test Plan:
- Writes 0x11,0x22,0x33,0x44 to byte addrs 0x100,0x104,0x108,0x10C; read 0x108 with rsp_ready=1, LATENCY=8:
  - rsp_valid rises 8 cycles after accept;
  - beats 0x11,0x22,0x33,0x44 on consecutive cycles, rsp_last only on 0x44;
  - rd_count=1, wr_count=4.
- Same read with rsp_ready toggled 1,0,0,1,0,1,1: each beat holds during the low cycles; exactly 4 handshakes; data order unchanged.
- Alias: write 0xDEAD at 0x0004_0100 (bit 18 set, MEM_AW=14); read 0x100: beat0 = 0xDEAD.
- Back-to-back: read, then write asserted continuously:
  - req_ready=0 throughout WAIT and BURST;
  - write accepted the cycle after the last beat's handshake returns to IDLE; wr_count+1.
- rst_n pulsed low during beat 2 of a burst:
  - rsp_valid=0 immediately; no further beats; rd_count unchanged;
  - after reset, rd_count=0 and a fresh read returns the prior array contents.
- LATENCY=1, LINE_WORDS=2: read accept at edge t0 -> rsp_valid at t1, rsp_last at t2 with rsp_ready=1; busy deasserts at t3.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared types, defaults and helpers for the cache memory responder
package cache_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LATENCY    = 8;
    localparam int DEF_MEM_AW     = 14;
    localparam int DEF_DATA_W     = 32;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/cache_mem_array.sv
// cache_mem_array: single-port synchronous word RAM with a registered, holdable read port
module cache_mem_array #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: main-memory side of the data cache; line-burst reads after a fixed
// latency, single-cycle word writes, and read/write transaction counters.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int MEM_AW     = DEF_MEM_AW,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);
    localparam int BW = clog2(LINE_WORDS);
    localparam int LW = clog2(LATENCY) + 1;
    state_t            state;
    logic [MEM_AW-1:0] idx, base, ram_addr;
    logic [BW-1:0]     beat;
    logic [LW-1:0]     lat_cnt;
    logic              hs, wr_acc, rd_acc, ram_re;
    logic              unused_addr_bits;
    assign idx              = req_addr[MEM_AW+1:2];
    assign unused_addr_bits = ^{req_addr[31:MEM_AW+2], req_addr[1:0]};
    assign req_ready        = state == IDLE;
    assign busy             = state != IDLE;
    assign wr_acc           = req_ready && req_valid && req_we;
    assign rd_acc           = req_ready && req_valid && !req_we;
    assign hs               = state == BURST && rsp_valid && rsp_ready;
    // The RAM output register is rsp_data: it loads the next beat ahead of each edge and holds otherwise.
    assign ram_addr = state == IDLE ? idx :
                      state == WAIT ? base : base + MEM_AW'(beat) + MEM_AW'(1);
    assign ram_re   = (state == WAIT && lat_cnt == '0) || (hs && !rsp_last);
    cache_mem_array #(.AW(MEM_AW), .DW(DATA_W)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (req_wdata),
        .rdata (rsp_data)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            beat      <= '0;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_acc) wr_count <= wr_count + 32'd1;
                    if (rd_acc) begin
                        base    <= idx & ~MEM_AW'(LINE_WORDS - 1);
                        beat    <= '0;
                        lat_cnt <= LW'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state     <= BURST;
                        rsp_valid <= 1'b1;
                        rsp_last  <= 1'b0;
                    end else lat_cnt <= lat_cnt - LW'(1);
                end
                BURST: begin
                    if (hs && rsp_last) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        rd_count  <= rd_count + 32'd1;
                        state     <= IDLE;
                    end else if (hs) begin
                        beat     <= beat + BW'(1);
                        rsp_last <= (beat + BW'(1)) == BW'(LINE_WORDS - 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: directed scenarios for the cache memory responder, including a
// LATENCY=1 / LINE_WORDS=2 instance for the minimum-timing case.
module tb_cache_mem_responder;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_last, busy;
    logic [31:0] rsp_data, rd_count, wr_count;
    logic        req_valid2 = 0, req_we2 = 0, rsp_ready2 = 0;
    logic [31:0] req_addr2 = 0, req_wdata2 = 0;
    logic        req_ready2, rsp_valid2, rsp_last2, busy2;
    logic [31:0] rsp_data2, rd_count2, wr_count2;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    cache_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
    );

    cache_mem_responder #(.LINE_WORDS(2), .LATENCY(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_data(rsp_data2), .rsp_last(rsp_last2), .busy(busy2), .rd_count(rd_count2), .wr_count(wr_count2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        req_valid = 1; req_we = 1; req_addr = a; req_wdata = d;
        tick;
        req_valid = 0; req_we = 0;
    endtask

    task automatic start_read(input logic [31:0] a);
        req_valid = 1; req_we = 0; req_addr = a;
        tick;
        req_valid = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin tick; n++; end
    endtask

    task automatic test_reset;
        rst_n = 0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %h exp 0", rsp_valid); end
        checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got %h exp 0", rsp_last); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        checks++; if (rd_count !== 32'h0 || wr_count !== 32'h0) begin errors++; $display("FAIL reset_counts got %h/%h exp 0/0", rd_count, wr_count); end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle got ready=%h busy=%h exp 1/0", req_ready, busy); end
        tick; tick;
        rst_n = 1;
        tick;
    endtask

    task automatic test_read_basic;
        logic [31:0] exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        int n;
        for (int i = 0; i < 4; i++) do_write(32'h100 + 32'(i * 4), exp[i]);
        checks++; if (wr_count !== 32'd4) begin errors++; $display("FAIL basic_wr_count got %0d exp 4", wr_count); end
        rsp_ready = 1;
        start_read(32'h108);
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%h ready=%h exp 1/0", busy, req_ready); end
        wait_valid(n);
        checks++; if (n != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_last !== (i == 3)) begin errors++; $display("FAIL basic_beat%0d got v=%h d=%h l=%h exp 1/%h/%h", i, rsp_valid, rsp_data, rsp_last, exp[i], i == 3); end
            tick;
        end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_end got v=%h busy=%h exp 0/0", rsp_valid, busy); end
        checks++; if (rd_count !== 32'd1 || wr_count !== 32'd4) begin errors++; $display("FAIL basic_counts got %0d/%0d exp 1/4", rd_count, wr_count); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int n, k;
        rsp_ready = 0;
        tick;
        start_read(32'h108);
        wait_valid(n);
        checks++; if (n != 8) begin errors++; $display("FAIL bp_latency got %0d exp 8", n); end
        k = 0;
        for (int i = 0; i < 7; i++) begin
            rsp_ready = pat[i];
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp[k] || rsp_last !== (k == 3)) begin errors++; $display("FAIL bp_cycle%0d got v=%h d=%h l=%h exp 1/%h/%h", i, rsp_valid, rsp_data, rsp_last, exp[k], k == 3); end
            if (pat[i]) k++;
            tick;
        end
        rsp_ready = 1;
        checks++; if (rsp_valid !== 1'b0 || rd_count !== 32'd2) begin errors++; $display("FAIL bp_end got v=%h rd=%0d exp 0/2", rsp_valid, rd_count); end
    endtask

    task automatic test_alias;
        logic [31:0] exp [4] = '{32'hDEAD, 32'h22, 32'h33, 32'h44};
        int n;
        tick;
        do_write(32'h0004_0100, 32'hDEAD);
        start_read(32'h100);
        wait_valid(n);
        checks++; if (n != 8) begin errors++; $display("FAIL alias_latency got %0d exp 8", n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_data !== exp[i] || rsp_last !== (i == 3)) begin errors++; $display("FAIL alias_beat%0d got d=%h l=%h exp %h/%h", i, rsp_data, rsp_last, exp[i], i == 3); end
            tick;
        end
        checks++; if (rd_count !== 32'd3 || wr_count !== 32'd5) begin errors++; $display("FAIL alias_counts got %0d/%0d exp 3/5", rd_count, wr_count); end
    endtask

    task automatic test_back_to_back;
        int n;
        tick;
        start_read(32'h100);
        req_valid = 1; req_we = 1; req_addr = 32'h200; req_wdata = 32'h55;
        n = 1;
        while (!req_ready && n < 40) begin
            checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_blocked got ready=%h busy=%h exp 0/1", req_ready, busy); end
            tick; n++;
        end
        checks++; if (n != 13) begin errors++; $display("FAIL b2b_idle_cycle got %0d exp 13", n); end
        checks++; if (wr_count !== 32'd5 || rd_count !== 32'd4) begin errors++; $display("FAIL b2b_before got wr=%0d rd=%0d exp 5/4", wr_count, rd_count); end
        tick;
        req_valid = 0; req_we = 0;
        checks++; if (wr_count !== 32'd6 || busy !== 1'b0) begin errors++; $display("FAIL b2b_write got wr=%0d busy=%h exp 6/0", wr_count, busy); end
    endtask

    task automatic test_reset_mid_burst;
        logic [31:0] exp [4] = '{32'hDEAD, 32'h22, 32'h33, 32'h44};
        int n;
        start_read(32'h100);
        wait_valid(n);
        tick; tick;
        checks++; if (rsp_data !== 32'h33 || rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_beat2 got v=%h d=%h exp 1/33", rsp_valid, rsp_data); end
        rst_n = 0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rd_count !== 32'd0) begin errors++; $display("FAIL rst_immediate got v=%h l=%h rd=%0d exp 0/0/0", rsp_valid, rsp_last, rd_count); end
        tick;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_residual%0d got v=%h busy=%h exp 0/0", i, rsp_valid, busy); end
            tick;
        end
        start_read(32'h104);
        wait_valid(n);
        checks++; if (n != 8) begin errors++; $display("FAIL rst_fresh_latency got %0d exp 8", n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_data !== exp[i] || rsp_last !== (i == 3)) begin errors++; $display("FAIL rst_fresh_beat%0d got d=%h l=%h exp %h/%h", i, rsp_data, rsp_last, exp[i], i == 3); end
            tick;
        end
        checks++; if (rd_count !== 32'd1 || wr_count !== 32'd0) begin errors++; $display("FAIL rst_fresh_counts got %0d/%0d exp 1/0", rd_count, wr_count); end
    endtask

    task automatic test_min_latency;
        rsp_ready2 = 1;
        req_valid2 = 1; req_we2 = 1; req_addr2 = 32'h0; req_wdata2 = 32'hA0;
        tick;
        req_addr2 = 32'h4; req_wdata2 = 32'hA1;
        tick;
        req_we2 = 0; req_addr2 = 32'h4;
        tick;
        req_valid2 = 0;
        checks++; if (rsp_valid2 !== 1'b0 || busy2 !== 1'b1) begin errors++; $display("FAIL min_t0 got v=%h busy=%h exp 0/1", rsp_valid2, busy2); end
        tick;
        checks++; if (rsp_valid2 !== 1'b1 || rsp_last2 !== 1'b0 || rsp_data2 !== 32'hA0) begin errors++; $display("FAIL min_t1 got v=%h l=%h d=%h exp 1/0/a0", rsp_valid2, rsp_last2, rsp_data2); end
        tick;
        checks++; if (rsp_valid2 !== 1'b1 || rsp_last2 !== 1'b1 || rsp_data2 !== 32'hA1) begin errors++; $display("FAIL min_t2 got v=%h l=%h d=%h exp 1/1/a1", rsp_valid2, rsp_last2, rsp_data2); end
        tick;
        checks++; if (rsp_valid2 !== 1'b0 || busy2 !== 1'b0 || rd_count2 !== 32'd1 || wr_count2 !== 32'd2) begin errors++; $display("FAIL min_t3 got v=%h busy=%h rd=%0d wr=%0d exp 0/0/1/2", rsp_valid2, busy2, rd_count2, wr_count2); end
    endtask

    initial begin
        test_reset;
        test_read_basic;
        test_backpressure;
        test_alias;
        test_back_to_back;
        test_reset_mid_burst;
        test_min_latency;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
